uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Runtime-configurable UART transmitter with small input FIFO. Serialises bytes LSB-first
//  with selectable data width (5-8), parity (none/even/odd) and stop bits (1/2). Baud strobe
//  from a 16-bit phase accumulator (strobe = carry of acc + cfg_inc). Sits between CPU/bus
//  logic and the board TX pin; valid/ready input replaces single-shot start pulse.
// PARAMETERS
//  FIFO_DEPTH  4   input FIFO entries; power of 2, >= 2
//  CNT_W       3   width of fifo_count = log2(FIFO_DEPTH)+1
// PORTS
//  clk_25mhz   in   1      system clock, 25 MHz
//  resetn      in   1      synchronous, active-low reset
//  cfg_inc     in   16     baud phase increment; baud = 25e6*cfg_inc/65536 (302 -> ~115200)
//  cfg_nbits   in   2      data bits: 0=5, 1=6, 2=7, 3=8
//  cfg_parity  in   2      0=none, 1=even, 2=odd, 3=none (reserved)
//  cfg_stop2   in   1      0=one stop bit, 1=two stop bits
//  in_data     in   8      byte to send; bits above cfg_nbits ignored
//  in_valid    in   1      producer has a byte
//  in_ready    out  1      FIFO not full; push when in_valid & in_ready
//  fifo_count  out  CNT_W  bytes waiting in FIFO (excludes frame in flight)
//  busy        out  1      high while a frame is on the line or FIFO non-empty
//  tx          out  1      serial output, idle high
// BEHAVIOUR
//  Reset: tx=1, in_ready=1, busy=0, fifo_count=0, FIFO empty, acc=0, state IDLE.
//  FIFO: push on in_valid&in_ready; in_ready=0 when full, pushes then ignored. Simultaneous
//   push+pop allowed whenever not full (count unchanged). Pop only at frame LOAD.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE: if FIFO non-empty and cfg_inc!=0: pop, latch byte + cfg_* for whole frame, acc<=0,
//   tx<=0 same edge, go START. cfg_inc==0: stay IDLE (transmitter disabled, FIFO still fills).
//  Each bit holds tx until next baud strobe (carry out of acc+cfg_inc); on strobe, drive next
//   bit: START->DATA bit0; DATA shifts LSB-first, after bit (nbits-1) -> PARITY if enabled,
//   else STOP; PARITY bit = XOR of data bits (even) or its inverse (odd); STOP drives tx=1
//   for 1 or 2 bit times; on final stop strobe -> IDLE.
//  Frame length = 1+N+P+S bit times (7..12). Back-to-back: next LOAD on first IDLE cycle,
//   so inter-frame gap is exactly one clock beyond the stop bits.
//  Config changes mid-frame have no effect until next LOAD. cfg_inc is sampled live (not latched).
//  acc runs only outside IDLE; in IDLE it holds 0.
//  busy = (state!=IDLE) | (fifo_count!=0).
//  Reset mid-frame: next cycle tx=1, FIFO flushed, frame abandoned (truncated on line).
//  Widths: acc 16b + carry, bit counter 4b, FIFO pointers log2(FIFO_DEPTH)+1 bits with wrap.
// STRUCTURE
//  uart_defs.vh (shared): parity codes PAR_NONE/PAR_EVEN/PAR_ODD, nbits encoding,
//   state encodings, default increment 16'd302 for 115200 at 25 MHz.
//  Sub-module uart_tx_fifo: sync FIFO (push/pop/full/empty/count); FSM + baud gen in top.
// TESTING (sim cfg_inc=16384 -> strobe every 4 clocks, bit time = 4 clk)
//  1. 8N1, push 0xA5 -> tx: 0,1,0,1,0,0,1,0,1,1 each 4 clk; busy drops with frame end.
//  2. 7E2, push 0x41 -> start, 1000001, parity 0, stop 1,1 (11 bit times); 7O1 -> parity 1.
//  3. 5N1, push 0xFF -> only 5 data ones sent, frame = 7 bit times; upper bits ignored.
//  4. Push 6 bytes back-to-back, FIFO_DEPTH=4 -> in_ready low when full, accepted bytes
//     sent in order, gap between frames = stop bits + 1 clk; dropped pushes absent.
//  5. cfg_inc=0 with 2 bytes pushed -> tx stays 1, fifo_count=2; set 16384 -> both sent.
//  6. Assert resetn=0 mid-data-bit -> tx=1 next clk, fifo_count=0, busy=0, in_ready=1.

Source files
------------

// File: rtl/uart_tx_cfg_pkg.sv
// uart_tx_cfg_pkg: shared parity codes, FSM state encodings, default baud increment and frame helpers
package uart_tx_cfg_pkg;
   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [15:0] INC_115200 = 16'd302;
   // nbits code 0..3 selects 5..8 data bits
   function automatic logic [7:0] data_mask(input logic [1:0] nbits);
      return 8'hFF >> (2'd3 - nbits);
   endfunction
   function automatic logic [3:0] last_data_idx(input logic [1:0] nbits);
      return {2'b00, nbits} + 4'd4;
   endfunction
   function automatic logic parity_on(input logic [1:0] par);
      return (par == PAR_EVEN) || (par == PAR_ODD);
   endfunction
endpackage

// File: rtl/uart_tx_cfg_fifo.sv
// uart_tx_cfg_fifo: synchronous byte FIFO feeding the transmitter
//   clk_25mhz, resetn : clock, synchronous active-low reset (flushes pointers)
//   push_i, data_i    : write request and byte, ignored while full
//   pop_i, data_o     : read request and head byte, ignored while empty
//   full_o, empty_o   : status flags
//   count_o           : bytes stored
module uart_tx_cfg_fifo #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk_25mhz,
   input  logic             resetn,
   input  logic             push_i,
   input  logic [7:0]       data_i,
   input  logic             pop_i,
   output logic [7:0]       data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);
   localparam int AW = CNT_W - 1;
   logic [7:0]       mem_q [DEPTH];
   logic [CNT_W-1:0] wr_q, rd_q;
   // pointers carry one extra wrap bit so full and empty differ
   assign count_o = wr_q - rd_q;
   assign full_o  = count_o == CNT_W'(DEPTH);
   assign empty_o = count_o == '0;
   assign data_o  = mem_q[rd_q[AW-1:0]];
   always_ff @(posedge clk_25mhz) begin
      if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= data_i;
   end
   always_ff @(posedge clk_25mhz) begin
      if (!resetn) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i && !full_o) wr_q <= wr_q + 1'b1;
         if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
      end
   end
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with input FIFO and phase-accumulator baud strobe
//   clk_25mhz, resetn      : clock, synchronous active-low reset
//   cfg_inc                : baud phase increment, 0 disables transmission (sampled live)
//   cfg_nbits/parity/stop2 : frame format, latched when a frame is loaded
//   in_data/valid/ready    : byte input handshake into the FIFO
//   fifo_count             : bytes waiting (excludes frame in flight)
//   busy                   : frame on the line or FIFO non-empty
//   tx                     : serial output, idle high
module uart_tx_cfg
   import uart_tx_cfg_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 3
) (
   input  logic             clk_25mhz,
   input  logic             resetn,
   input  logic [15:0]      cfg_inc,
   input  logic [1:0]       cfg_nbits,
   input  logic [1:0]       cfg_parity,
   input  logic             cfg_stop2,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [CNT_W-1:0] fifo_count,
   output logic             busy,
   output logic             tx
);
   logic [2:0]  state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [7:0]  shift_q, shift_d;
   logic [3:0]  bitcnt_q, bitcnt_d;
   logic [1:0]  nbits_q, nbits_d;
   logic        par_en_q, par_en_d;
   logic        par_bit_q, par_bit_d;
   logic        stop2_q, stop2_d;
   logic        tx_q, tx_d;
   logic        pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_data, load_byte;
   logic [16:0] acc_sum;
   logic        strobe;
   uart_tx_cfg_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk_25mhz (clk_25mhz),
      .resetn    (resetn),
      .push_i    (in_valid),
      .data_i    (in_data),
      .pop_i     (pop),
      .data_o    (fifo_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );
   assign acc_sum   = {1'b0, acc_q} + {1'b0, cfg_inc};
   assign strobe    = acc_sum[16];
   assign load_byte = fifo_data & data_mask(cfg_nbits);
   assign in_ready  = !fifo_full;
   assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);
   assign tx        = tx_q;
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_sum[15:0];
      shift_d   = shift_q;
      bitcnt_d  = bitcnt_q;
      nbits_d   = nbits_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      stop2_d   = stop2_q;
      tx_d      = tx_q;
      pop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            acc_d = '0;
            if (!fifo_empty && cfg_inc != '0) begin
               pop       = 1'b1;
               shift_d   = load_byte;
               nbits_d   = cfg_nbits;
               par_en_d  = parity_on(cfg_parity);
               par_bit_d = (^load_byte) ^ (cfg_parity == PAR_ODD);
               stop2_d   = cfg_stop2;
               tx_d      = 1'b0;
               state_d   = ST_START;
            end
         end
         ST_START: if (strobe) begin
            tx_d     = shift_q[0];
            shift_d  = shift_q >> 1;
            bitcnt_d = '0;
            state_d  = ST_DATA;
         end
         ST_DATA: if (strobe) begin
            if (bitcnt_q == last_data_idx(nbits_q)) begin
               tx_d     = par_en_q ? par_bit_q : 1'b1;
               bitcnt_d = '0;
               state_d  = par_en_q ? ST_PARITY : ST_STOP;
            end else begin
               tx_d     = shift_q[0];
               shift_d  = shift_q >> 1;
               bitcnt_d = bitcnt_q + 1'b1;
            end
         end
         ST_PARITY: if (strobe) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
         end
         ST_STOP: if (strobe) begin
            // bitcnt counts completed stop bits; the last one returns to IDLE with acc cleared
            if (bitcnt_q[0] == stop2_q) begin
               state_d = ST_IDLE;
               acc_d   = '0;
            end else bitcnt_d = bitcnt_q + 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            acc_d   = '0;
            tx_d    = 1'b1;
         end
      endcase
   end
   always_ff @(posedge clk_25mhz) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         shift_q   <= '0;
         bitcnt_q  <= '0;
         nbits_q   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         shift_q   <= shift_d;
         bitcnt_q  <= bitcnt_d;
         nbits_q   <= nbits_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         stop2_q   <= stop2_d;
         tx_q      <= tx_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed and randomized frame checks of uart_tx_cfg against an arithmetic line model
module tb_uart_tx_cfg;
   logic        clk_25mhz = 1'b0;
   logic        resetn = 1'b0;
   logic [15:0] cfg_inc = '0;
   logic [1:0]  cfg_nbits = 2'd3;
   logic [1:0]  cfg_parity = 2'd0;
   logic        cfg_stop2 = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  fifo_count;
   logic        busy;
   logic        tx;
   int          vecs = 0;
   int          errs = 0;
   int          mcnt = 0;
   logic [7:0]  sb[$];
   uart_tx_cfg #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
      .clk_25mhz  (clk_25mhz),
      .resetn     (resetn),
      .cfg_inc    (cfg_inc),
      .cfg_nbits  (cfg_nbits),
      .cfg_parity (cfg_parity),
      .cfg_stop2  (cfg_stop2),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .fifo_count (fifo_count),
      .busy       (busy),
      .tx         (tx)
   );
   always #20 clk_25mhz = ~clk_25mhz;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vecs++;
      assert (obs === exp_v) else begin
         errs++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
   endtask
   task automatic push(input logic [7:0] b);
      @(negedge clk_25mhz);
      in_valid = 1'b1;
      in_data  = b;
      chk("in_ready", 32'(in_ready), 32'(mcnt < 4));
      if (mcnt < 4) begin
         sb.push_back(b);
         mcnt++;
      end
   endtask
   task automatic end_push();
      @(negedge clk_25mhz);
      in_valid = 1'b0;
   endtask
   // Line model: after the load edge, k edges in, the bit on the line is floor(k*inc/2^16)
   task automatic check_frame(input logic [7:0] d, input bit imm, input bit scr);
      int      nbits, b, idx, w;
      longint  inc;
      logic [1:0] par;
      logic    p;
      logic    bits[16];
      par   = cfg_parity;
      nbits = 5 + int'(cfg_nbits);
      inc   = longint'(cfg_inc);
      p     = 1'b0;
      bits[0] = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         bits[1+i] = d[i];
         p ^= d[i];
      end
      b = 1 + nbits;
      if (par == 2'd1 || par == 2'd2) begin
         bits[b] = p ^ (par == 2'd2);
         b++;
      end
      bits[b] = 1'b1;
      b++;
      if (cfg_stop2) begin
         bits[b] = 1'b1;
         b++;
      end
      w = 0;
      if (imm) begin
         @(negedge clk_25mhz);
         chk("start_b2b", 32'(tx), 32'd0);
      end else begin
         while (tx !== 1'b0 && w < 2000) begin
            @(negedge clk_25mhz);
            w++;
         end
         chk("start", 32'(tx), 32'd0);
      end
      mcnt--;
      if (scr) begin
         cfg_nbits  = 2'($urandom);
         cfg_parity = 2'($urandom);
         cfg_stop2  = 1'($urandom);
      end
      for (int k = 1; k < 5000; k++) begin
         @(negedge clk_25mhz);
         idx = int'((longint'(k) * inc) >>> 16);
         if (idx >= b) begin
            chk("stop_end", 32'(tx), 32'd1);
            break;
         end
         chk($sformatf("bit%0d", idx), 32'(tx), 32'(bits[idx]));
      end
      chk("busy_end", 32'(busy), 32'(mcnt != 0));
   endtask
   initial begin
      bit idle_ok;
      int n;
      repeat (3) @(negedge clk_25mhz);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      resetn = 1'b1;
      cfg_inc = 16'd16384;
      // 8N1 0xA5
      push(8'hA5); end_push();
      check_frame(sb.pop_front(), 1'b0, 1'b0);
      // 7E2 0x41, then 7O1 0x41
      cfg_nbits = 2'd2; cfg_parity = 2'd1; cfg_stop2 = 1'b1;
      push(8'h41); end_push();
      check_frame(sb.pop_front(), 1'b0, 1'b0);
      cfg_parity = 2'd2; cfg_stop2 = 1'b0;
      push(8'h41); end_push();
      check_frame(sb.pop_front(), 1'b0, 1'b0);
      // 5N1 0xFF: upper bits ignored
      cfg_nbits = 2'd0; cfg_parity = 2'd0;
      push(8'hFF); end_push();
      check_frame(sb.pop_front(), 1'b0, 1'b0);
      // overfill with transmitter disabled, then drain back-to-back
      cfg_inc = '0; cfg_nbits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
      for (int i = 0; i < 6; i++) push(8'(8'h11 * i + 8'h01));
      end_push();
      chk("full_count", 32'(fifo_count), 32'd4);
      chk("full_ready", 32'(in_ready), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      cfg_inc = 16'd16384;
      for (int i = 0; i < 4; i++) check_frame(sb.pop_front(), i != 0, 1'b0);
      // disabled transmitter holds the line and keeps the bytes
      cfg_inc = '0;
      push(8'h3C); push(8'hC3); end_push();
      idle_ok = 1'b1;
      repeat (20) begin
         @(negedge clk_25mhz);
         if (tx !== 1'b1) idle_ok = 1'b0;
      end
      chk("dis_tx_idle", 32'(idle_ok), 32'd1);
      chk("dis_count", 32'(fifo_count), 32'd2);
      cfg_inc = 16'd16384;
      for (int i = 0; i < 2; i++) check_frame(sb.pop_front(), i != 0, 1'b0);
      // reset in the middle of a data bit
      push(8'h00); push(8'h5A); end_push();
      n = 0;
      while (tx !== 1'b0 && n < 200) begin
         @(negedge clk_25mhz);
         n++;
      end
      repeat (6) @(negedge clk_25mhz);
      resetn = 1'b0;
      @(negedge clk_25mhz);
      chk("mid_rst_tx", 32'(tx), 32'd1);
      chk("mid_rst_count", 32'(fifo_count), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      resetn = 1'b1;
      sb.delete();
      mcnt = 0;
      idle_ok = 1'b1;
      repeat (30) begin
         @(negedge clk_25mhz);
         if (tx !== 1'b1) idle_ok = 1'b0;
      end
      chk("post_rst_idle", 32'(idle_ok), 32'd1);
      // randomized formats, rates, bursts and mid-frame config changes
      for (int r = 0; r < 12; r++) begin
         cfg_inc    = '0;
         cfg_nbits  = 2'($urandom);
         cfg_parity = 2'($urandom);
         cfg_stop2  = 1'($urandom);
         n = int'($urandom_range(1, 3));
         for (int i = 0; i < n; i++) push(8'($urandom));
         end_push();
         cfg_inc = 16'($urandom_range(4096, 65535));
         for (int i = 0; i < n; i++) check_frame(sb.pop_front(), i != 0, 1'($urandom_range(0, 1)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
